tb_clkdiv_seq: RTL
==================

# tb_clkdiv_seq

Multi-channel clock-enable and reset sequencer for the 6502 simulation and bring-up harness. It runs from one free-running base clock. It produces:
- a stretched, synchronous reset;
- NCH independently divided clock-enable strobes with programmable divisor and start phase, plus matching divided square waves;
- a free-running cycle timestamp.

It generalises the fixed single-period bench clock source into a programmable, phase-controlled, multi-rate source. Benches and peripheral models key off a common base clock through it.

## Interface
- NCH, 4, number of output channels
- DIVW, 8, divisor/phase field width per channel
- RST_HOLD, 16, base cycles rst_o stays high after rst deasserts (≥1)
- CNTW, 32, cycle timestamp width
- clk  input  1  base clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- div_i  input  NCH*DIVW  per-channel divisor, channel k in bits [k*DIVW +: DIVW]; 0 = channel disabled
- phase_i  input  NCH*DIVW  per-channel start phase, same packing
- rst_o  output  1  stretched reset for downstream logic, active-high
- en_o  output  NCH  per-channel single-cycle enable strobe
- clk_o  output  NCH  per-channel divided square wave
- cycle_o  output  CNTW  base cycles since rst_o deasserted

## Operation
Reset sequencer:
- States are RESET, HOLD and RUN.
- rst=1 forces RESET from any state. In RESET, the hold counter is cleared.
- On the first cycle with rst=0, RESET moves to HOLD.
- HOLD counts RST_HOLD cycles and then moves to RUN.
- rst_o=1 in RESET and HOLD; rst_o=0 in RUN.

Channel k, with divisor d = div_i[k] and phase p = phase_i[k]:
- A down-counter cnt_k and a latched divisor dl_k are kept per channel.
- While rst_o=1 or dl_k=0: cnt_k loads min(p, d−1) and dl_k loads d every cycle; en_o[k]=0 and clk_o[k]=0.
- In RUN with dl_k≠0:
  - en_o[k]=1 exactly when cnt_k==0.
  - When cnt_k==0, cnt_k reloads dl_k−1 next cycle and dl_k re-samples div_i[k]. Divisor changes therefore take effect only at a period boundary, so there are no runt periods.
  - Otherwise cnt_k decrements.
- clk_o[k]=1 when cnt_k ≥ floor(dl_k/2). This gives a high time of ceil(d/2) cycles and a low time of floor(d/2) cycles.
- d=1 gives en_o[k] every cycle and clk_o[k] constantly 1.
- Disabling: a channel running at d≠0 stops only at its next boundary. If the sampled div_i[k] is 0, outputs go to 0 from the next cycle.
- Enabling: a disabled channel (dl_k=0) samples div_i[k] every cycle. When it becomes non-zero, cnt_k loads min(p, d−1) and counting starts the following cycle.
- Phase arithmetic is unsigned DIVW-bit. p ≥ d clamps to d−1; there is no modulo.

cycle_o:
- Equals 0 while rst_o=1.
- In RUN it increments every cycle, starting from 0 in the first RUN cycle.
- Wraps modulo 2^CNTW.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Values during rst=1: rst_o=1, en_o=0, clk_o=0, cycle_o=0, state RESET.
- If rst deasserts after edge T, rst_o first reads 0 RST_HOLD+1 cycles later. This is the first RUN cycle, R.
- The first en_o[k] strobe is in cycle R+min(p,d−1). The period thereafter is exactly d cycles.
- Asserting rst mid-run takes effect on the next posedge: all outputs return to reset values in one cycle, and the full RST_HOLD sequence repeats on release.
- Channels are mutually independent. Equal d and p give strobes in the same cycle.

## Test plan
- Reset stretch: RST_HOLD=16, rst high for 3 cycles then low -> rst_o low exactly 17 cycles after the last rst-high edge; cycle_o=0 in that cycle, then 1, 2, 3…
- Divide/phase: ch0 d=4 p=0, ch1 d=4 p=2, ch2 d=3 p=5 (clamped to 2), ch3 d=0 -> en_o[0] at R, R+4…; en_o[1] at R+2, R+6…; en_o[2] at R+2, R+5…; clk_o[2] pattern 1,1,0; ch3 outputs stay 0.
- Boundary divisors: d=1 -> en_o every cycle and clk_o=1; d=255 -> one strobe per 255 cycles, high 128 / low 127.
- Glitch-free retune: ch0 d=5 running, div_i changed to 2 mid-period -> the current 5-cycle period completes, then period 2 follows; no strobe spacing outside {5,2}.
- Enable/disable: div_i[1] 0→6 at cycle X in RUN with p=0 -> first strobe at X+1; then set to 0 -> outputs go to 0 after the next strobe.
- Mid-run reset and wrap: assert rst for 1 cycle during RUN -> en_o/clk_o/cycle_o go to 0 next cycle and HOLD repeats. With CNTW=4, cycle_o wraps 15→0.

Source files
------------

// File: rtl/tb_clkdiv_seq_if.sv
// Bundle of programming inputs and divided outputs for the
// bench clock-enable / reset sequencer.
interface tb_clkdiv_seq_if #(
    parameter int NCH  = 4,
    parameter int DIVW = 8,
    parameter int CNTW = 32
);
    logic [NCH*DIVW-1:0] div_i;
    logic [NCH*DIVW-1:0] phase_i;
    logic                rst_o;
    logic [NCH-1:0]      en_o;
    logic [NCH-1:0]      clk_o;
    logic [CNTW-1:0]     cycle_o;

    modport master (
        output div_i,
        output phase_i,
        input  rst_o,
        input  en_o,
        input  clk_o,
        input  cycle_o
    );

    modport slave (
        input  div_i,
        input  phase_i,
        output rst_o,
        output en_o,
        output clk_o,
        output cycle_o
    );
endinterface

// File: rtl/tb_clkdiv_seq.sv
// Stretched reset sequencer with NCH phase-controlled clock-enable
// dividers and a free-running cycle timestamp.
module tb_clkdiv_seq #(
    parameter int NCH      = 4,
    parameter int DIVW     = 8,
    parameter int RST_HOLD = 16,
    parameter int CNTW     = 32
) (
    input  logic            clk,
    input  logic            rst,
    tb_clkdiv_seq_if.slave  bus
);
    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

    typedef enum logic [1:0] {
        S_RESET,
        S_HOLD,
        S_RUN
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [CNTW-1:0] cyc_q, cyc_d;
    logic            run;

    assign run = (state_q == S_RUN);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            S_RESET: begin
                hold_d  = '0;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_RESET;
                hold_d  = '0;
            end
        endcase
        if (rst) begin
            state_d = S_RESET;
            hold_d  = '0;
        end
    end

    // Timestamp is zero in the first RUN cycle and whenever not running.
    always_comb begin
        cyc_d = '0;
        if (state_d == S_RUN && state_q == S_RUN) begin
            cyc_d = cyc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RESET;
            hold_q  <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cyc_q   <= cyc_d;
        end
    end

    assign bus.rst_o   = ~run;
    assign bus.cycle_o = cyc_q;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [DIVW-1:0] d, p, dm1, start;
        logic [DIVW-1:0] cnt_q, cnt_d;
        logic [DIVW-1:0] dl_q, dl_d;
        logic            act;

        assign d     = bus.div_i[k*DIVW +: DIVW];
        assign p     = bus.phase_i[k*DIVW +: DIVW];
        assign dm1   = d - 1'b1;
        assign start = (p > dm1) ? dm1 : p;
        assign act   = run && (dl_q != '0);

        // The divisor is only re-sampled at a period boundary,
        // so a retune never produces a runt period.
        always_comb begin
            cnt_d = cnt_q;
            dl_d  = dl_q;
            if (!act) begin
                cnt_d = start;
                dl_d  = d;
            end else if (cnt_q == '0) begin
                cnt_d = dm1;
                dl_d  = d;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
                dl_q  <= '0;
            end else begin
                cnt_q <= cnt_d;
                dl_q  <= dl_d;
            end
        end

        assign bus.en_o[k]  = act && (cnt_q == '0);
        assign bus.clk_o[k] = act && (cnt_q >= (dl_q >> 1));
    end
endmodule
